// File: rtl/md_pkg.sv
// Shared types and constants for the intra mode-decision bank/NZC block.
package md_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } md_state_e;

  localparam int COEFF_WIDTH_D = 16;
  localparam int ROW_PIX_D     = 32;
  localparam int IDX_W_D       = 5;
  localparam int BANK_NUM_D    = 3;
  localparam int BANK_W_D      = 2;
  localparam int TU_NUM_D      = 16;
  localparam int NZC_W_D       = 13;

  // err_o bit positions
  localparam int ERR_IDX  = 0;  // row index did not follow 0,1,2,...
  localparam int ERR_TUOV = 1;  // more TUs closed than cbf bits available

endpackage

// File: rtl/md_bank_nzc_if.sv
// Coefficient write bus plus result handshake between TQ, MD and EC/DB.
interface md_bank_nzc_if #(
  parameter int COEFF_WIDTH = 16,
  parameter int ROW_PIX     = 32,
  parameter int IDX_W       = 5,
  parameter int TU_NUM      = 16,
  parameter int NZC_W       = 13
) ();
  localparam int TUC_W = $clog2(TU_NUM) + 1;

  logic                           cef_wen_i;
  logic [IDX_W-1:0]               cef_widx_i;
  logic [COEFF_WIDTH*ROW_PIX-1:0] cef_data_i;
  logic                           cef_tu_last_i;
  logic                           cef_lcu_last_i;
  logic                           md_valid_o;
  logic                           md_ready_i;
  logic [NZC_W-1:0]               db_non_zero_count_o;
  logic [TU_NUM-1:0]              ec_cbf_o;
  logic [TUC_W-1:0]               ec_tu_cnt_o;
  logic [1:0]                     err_o;

  // MD block side
  modport slave (
    input  cef_wen_i, cef_widx_i, cef_data_i, cef_tu_last_i, cef_lcu_last_i, md_ready_i,
    output md_valid_o, db_non_zero_count_o, ec_cbf_o, ec_tu_cnt_o, err_o
  );

  // TQ / EC / DB side
  modport master (
    output cef_wen_i, cef_widx_i, cef_data_i, cef_tu_last_i, cef_lcu_last_i, md_ready_i,
    input  md_valid_o, db_non_zero_count_o, ec_cbf_o, ec_tu_cnt_o, err_o
  );
endinterface

// File: rtl/md_popcnt.sv
// Non-zero coefficient count of one row as a balanced adder tree.
// Level 0 holds one "is non-zero" bit per coefficient; each higher level sums pairs.
module md_popcnt #(
  parameter int ROW_PIX     = 32,
  parameter int COEFF_WIDTH = 16
) (
  input  logic [ROW_PIX*COEFF_WIDTH-1:0] row_i,
  output logic [$clog2(ROW_PIX):0]       cnt_o
);
  localparam int LV    = $clog2(ROW_PIX);
  localparam int CNT_W = LV + 1;

  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    logic [CNT_W-1:0] s [ROW_PIX>>l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < ROW_PIX; i++) begin : g_n
        assign s[i] = {{(CNT_W-1){1'b0}}, |row_i[i*COEFF_WIDTH +: COEFF_WIDTH]};
      end
    end else begin : g_add
      for (genvar i = 0; i < (ROW_PIX>>l); i++) begin : g_n
        assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
      end
    end
  end

  assign cnt_o = g_lvl[LV].s[0];
endmodule

// File: rtl/md_bank_nzc.sv
// Per-LCU bank rotation, non-zero coefficient accounting, cbf vector and
// protocol error flags, released to EC/DB through a valid/ready handshake.
module md_bank_nzc
  import md_pkg::*;
#(
  parameter int COEFF_WIDTH = COEFF_WIDTH_D,
  parameter int ROW_PIX     = ROW_PIX_D,
  parameter int IDX_W       = IDX_W_D,
  parameter int BANK_NUM    = BANK_NUM_D,
  parameter int BANK_W      = BANK_W_D,
  parameter int TU_NUM      = TU_NUM_D,
  parameter int NZC_W       = NZC_W_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              start_drop_o,
  output logic [BANK_W-1:0] ipre_bank_o,
  output logic [BANK_W-1:0] ec_bank_o,
  output logic [BANK_W-1:0] db_bank_o,
  md_bank_nzc_if.slave      bus
);
  localparam int CNT_W = $clog2(ROW_PIX) + 1;
  localparam int TUC_W = $clog2(TU_NUM) + 1;
  localparam int TUI_W = $clog2(TU_NUM);

  md_state_e         state_q, state_d;
  logic [BANK_W-1:0] ipre_q, ipre_d, ec_q, ec_d, db_q, db_d;
  logic              drop_q, drop_d;
  logic [NZC_W-1:0]  acc_q, acc_d;
  logic [TU_NUM-1:0] cbf_q, cbf_d;
  logic [TUC_W-1:0]  tu_cnt_q, tu_cnt_d;
  logic [IDX_W-1:0]  exp_idx_q, exp_idx_d;
  logic              tu_nz_q, tu_nz_d;    // current TU has seen a non-zero row
  logic [1:0]        err_q, err_d;

  logic [CNT_W-1:0]  row_cnt;
  logic              accept, wr, tu_close, row_nz;
  logic [NZC_W:0]    acc_sum;

  md_popcnt #(.ROW_PIX(ROW_PIX), .COEFF_WIDTH(COEFF_WIDTH)) u_popcnt (
    .row_i (bus.cef_data_i),
    .cnt_o (row_cnt)
  );

  // Next-state: FSM, start acceptance, bank rotation, row/TU accounting
  always_comb begin
    state_d   = state_q;
    ipre_d    = ipre_q;
    ec_d      = ec_q;
    db_d      = db_q;
    drop_d    = 1'b0;
    acc_d     = acc_q;
    cbf_d     = cbf_q;
    tu_cnt_d  = tu_cnt_q;
    exp_idx_d = exp_idx_q;
    tu_nz_d   = tu_nz_q;
    err_d     = err_q;

    accept   = start_i && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.md_ready_i));
    wr       = bus.cef_wen_i && (state_q == ST_RUN);
    tu_close = bus.cef_tu_last_i || bus.cef_lcu_last_i;
    row_nz   = (row_cnt != '0);
    acc_sum  = {1'b0, acc_q} + (NZC_W+1)'(row_cnt);

    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN:  if (wr && bus.cef_lcu_last_i) state_d = ST_HOLD;
      ST_HOLD: if (bus.md_ready_i) state_d = start_i ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (start_i && !accept) drop_d = 1'b1;

    if (accept) begin
      ipre_d    = (ipre_q == BANK_W'(BANK_NUM-1)) ? '0 : ipre_q + 1'b1;
      ec_d      = ipre_q;
      db_d      = ec_q;
      acc_d     = '0;
      cbf_d     = '0;
      tu_cnt_d  = '0;
      exp_idx_d = '0;
      tu_nz_d   = 1'b0;
      err_d     = '0;
    end

    if (wr) begin
      acc_d = acc_sum[NZC_W] ? '1 : acc_sum[NZC_W-1:0];
      if (bus.cef_widx_i != exp_idx_q) err_d[ERR_IDX] = 1'b1;
      if (tu_close) begin
        exp_idx_d = '0;
        tu_nz_d   = 1'b0;
        if (tu_cnt_q < TUC_W'(TU_NUM)) begin
          cbf_d[tu_cnt_q[TUI_W-1:0]] = tu_nz_q || row_nz;
          tu_cnt_d = tu_cnt_q + 1'b1;
        end else begin
          err_d[ERR_TUOV] = 1'b1;
        end
      end else begin
        exp_idx_d = exp_idx_q + 1'b1;
        tu_nz_d   = tu_nz_q || row_nz;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ipre_q    <= '0;
      ec_q      <= BANK_W'(BANK_NUM-1);
      db_q      <= BANK_W'(BANK_NUM-2);
      drop_q    <= 1'b0;
      acc_q     <= '0;
      cbf_q     <= '0;
      tu_cnt_q  <= '0;
      exp_idx_q <= '0;
      tu_nz_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      ipre_q    <= ipre_d;
      ec_q      <= ec_d;
      db_q      <= db_d;
      drop_q    <= drop_d;
      acc_q     <= acc_d;
      cbf_q     <= cbf_d;
      tu_cnt_q  <= tu_cnt_d;
      exp_idx_q <= exp_idx_d;
      tu_nz_q   <= tu_nz_d;
      err_q     <= err_d;
    end
  end

  assign start_drop_o            = drop_q;
  assign ipre_bank_o             = ipre_q;
  assign ec_bank_o               = ec_q;
  assign db_bank_o               = db_q;
  assign bus.md_valid_o          = (state_q == ST_HOLD);
  assign bus.db_non_zero_count_o = acc_q;
  assign bus.ec_cbf_o            = cbf_q;
  assign bus.ec_tu_cnt_o         = tu_cnt_q;
  assign bus.err_o               = err_q;
endmodule

// File: doc/md_bank_nzc.md
# md_bank_nzc

Parametrised intra mode-decision bookkeeping block for the H.265 encoder LCU pipeline. It rotates the memory-bank selects handed to intra prediction, the CABAC entropy coder and the deblocking filter, one step per LCU. It consumes TQ coefficient rows and produces, per LCU:
- the total non-zero coefficient count;
- a coded-block-flag vector indexed by TU;
- sticky protocol-error flags.

Results are released to EC/DB through a valid/ready handshake.

## Interface
Parameters:
- COEFF_WIDTH, 16, bits per TQ coefficient
- ROW_PIX, 32, coefficients per written row
- IDX_W, 5, row-index width (log2 ROW_PIX)
- BANK_NUM, 3, number of rotating banks (≥3)
- BANK_W, 2, bank-select width (≥ log2 BANK_NUM)
- TU_NUM, 16, maximum TUs tracked per LCU
- NZC_W, 13, non-zero count width (64×64 LCU)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- start_i  in  1  new-LCU pulse
- start_drop_o  out  1  one-cycle pulse: start_i was ignored
- ipre_bank_o  out  BANK_W  bank select for intra predicted pixels
- ec_bank_o  out  BANK_W  bank select for CABAC
- db_bank_o  out  BANK_W  bank select for deblocking
- cef_wen_i  in  1  coefficient row write enable
- cef_widx_i  in  IDX_W  row index within the current TU
- cef_data_i  in  COEFF_WIDTH*ROW_PIX  row coefficients
- cef_tu_last_i  in  1  qualifies a write as the last row of a TU
- cef_lcu_last_i  in  1  qualifies a write as the last row of the LCU (implies TU last)
- md_valid_o  out  1  LCU result valid
- md_ready_i  in  1  EC/DB accept
- db_non_zero_count_o  out  NZC_W  LCU non-zero coefficient count
- ec_cbf_o  out  TU_NUM  per-TU coded-block flags; bit k = TU k
- ec_tu_cnt_o  out  log2(TU_NUM)+1  number of TUs closed
- err_o  out  2  bit0 = row-index mismatch, bit1 = TU overflow; both sticky

## Operation
- **FSM states:** IDLE, RUN, HOLD.
  - IDLE: start_i → RUN.
  - RUN: write with cef_lcu_last_i → HOLD.
  - HOLD with md_ready_i → IDLE. If start_i is also high that cycle, go → RUN instead (back-to-back LCUs).
- **Start acceptance:** start_i is accepted in IDLE, or in HOLD together with md_ready_i. In any other case it is dropped and start_drop_o pulses for one cycle.
- **On an accepted start:**
  - Bank rotation: ipre_bank_o ← (ipre_bank_o+1) mod BANK_NUM, ec_bank_o ← old ipre_bank_o, db_bank_o ← old ec_bank_o.
  - Cleared: the accumulator, ec_cbf_o, the TU counter, the row counter and err_o.
- **Row writes in RUN:**
  - Row count = number of the ROW_PIX coefficients that are ≠ 0.
  - The row count is added to both the LCU accumulator and the TU accumulator. The LCU accumulator saturates at 2^NZC_W−1.
  - The expected row index starts at 0 per TU and increments per write. If cef_widx_i ≠ expected, set err_o[0]; the write is still counted.
- **TU close:** a write with cef_tu_last_i or cef_lcu_last_i closes the TU.
  - ec_cbf_o[tu] ← (TU count including this row ≠ 0).
  - The TU counter increments and the row counter resets.
  - If the TU index ≥ TU_NUM: set err_o[1], do not write the cbf, and saturate the TU counter at TU_NUM.
- **Writes in IDLE or HOLD** are ignored and change no state.
- **In HOLD:** md_valid_o=1 and the result outputs are held stable until the accept cycle.

## Timing
- Reset values:
  - FSM = IDLE
  - ipre_bank_o = 0, ec_bank_o = BANK_NUM−1, db_bank_o = BANK_NUM−2
  - md_valid_o = 0, start_drop_o = 0, err_o = 0
  - db_non_zero_count_o = 0, ec_cbf_o = 0, ec_tu_cnt_o = 0
- Bank selects update in the cycle after the accepted start_i edge.
- Row counts are combinational into the accumulator; each write is reflected one cycle later.
- The last-row write at edge N gives md_valid_o=1 at N+1, with the count including that row.
- Handshake: the transfer completes on the edge where md_valid_o & md_ready_i. md_valid_o falls the next cycle unless a back-to-back start was accepted; in that case it also falls, because the state is RUN.
- When reset is asserted mid-LCU, all state returns to the reset values on the next edge; partial results are discarded.

## Structure
- **Package md_pkg:**
  - FSM state enum (IDLE/RUN/HOLD)
  - default parameter constants
  - err_o bit-position constants
- **Sub-module md_popcnt:** parametrised by ROW_PIX and COEFF_WIDTH. It counts the non-zero coefficients in one row as a balanced adder tree, with output width log2(ROW_PIX)+1.
- **Top level:** FSM, bank rotator, accumulators, cbf register and error flags.

## Test plan
- **Reset then 3 back-to-back starts:** banks after reset are (ipre,ec,db) = (0,2,1). After the three starts they step (1,0,2) → (2,1,0) → (0,2,1).
- **One LCU:** two TUs of 4 rows each, with per-row non-zero counts 3,0,0,1 and 0,0,0,0, lcu_last on row 8.
  - md_valid_o rises 1 cycle later with count=4, ec_cbf_o=0b01, ec_tu_cnt_o=2.
  - Holding md_ready_i=0 for 5 cycles keeps all outputs stable.
- **start_i in RUN:** start_drop_o pulses and the banks are unchanged. In HOLD with md_ready_i=1 and start_i=1, the block enters RUN and the banks rotate in the same step.
- **Row-index error:** cef_widx_i sequence 0,1,3 gives err_o[0]=1 and all rows are still counted. Error and TU-overflow flags clear on the next accepted start.
- **Saturation and overflow:** 17 TUs with TU_NUM=16 set err_o[1] and ec_tu_cnt_o=16. 4096 all-non-zero rows of 32 saturate the count at 8191.
- **Reset mid-LCU:** rst_n low mid-RUN for 1 cycle returns to IDLE with all reset values. The next LCU's count excludes earlier rows.
